uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Serial receiver that decodes UART frames from the line driven by the team's UART TX block: start bit, data LSB-first, optional parity, one stop bit.
- Oversamples rx_in by a runtime prescale and majority-votes 3 samples per bit.
- Checks parity and stop bit.
- Delivers each good byte as a one-cycle data_valid pulse to the downstream data-sync/register stage.

Parameters:
datawidth, 8, number of data bits per frame.
prescale_w, 6, width of the prescale input.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
rx_in  input  1  raw serial line, idle high, asynchronous to clk.
prescale  input  prescale_w  oversampling ratio (clk cycles per bit); legal values 8, 16, 32.
par_en  input  1  1 = frame carries a parity bit.
par_typ  input  1  0 = even parity, 1 = odd parity.
p_data  output  datawidth  last good received word; holds between frames.
data_valid  output  1  one-cycle pulse: p_data updated with a good word.
par_err  output  1  one-cycle pulse: parity mismatch in the frame just ended.
stop_err  output  1  one-cycle pulse: stop bit sampled as 0.

Behaviour:
Reset:
- rst asserts asynchronously and sets all outputs to 0.
- Synchronizer flops reset to 1.
- FSM goes to IDLE; edge and bit counters go to 0.

Synchronization:
- rx_in passes through a 2-flop synchronizer (rx_s). All logic uses rx_s.
- Latency from rx_in to rx_s is 2 cycles.

Configuration latching:
- prescale, par_en and par_typ are latched when leaving IDLE.
- Changes to these inputs mid-frame are ignored.
- Prescale values other than 8/16/32 give undefined results.

Counters:
- edge_cnt runs 0..P-1 per bit period, where P is the latched prescale, then wraps to 0.
- bit_cnt counts data bits 0..datawidth-1.

Sampling:
- Samples are taken at edges P/2-1, P/2 and P/2+1.
- The bit value is the majority of the 3 samples; it is valid from edge P/2+2 onward.

States:
- IDLE: the first cycle with rx_s=0 counts as edge 0 of the start bit; go to START.
- START: at edge P-1, go to DATA if the voted bit is 0; otherwise treat it as a glitch and return to IDLE with no output pulses.
- DATA: at each edge P-1, shift the voted bit into the shift register LSB-first. After bit datawidth-1, go to PARITY if par_en, else STOP.
- PARITY: compute expected parity = XOR of the data bits, inverted if par_typ=1. At edge P-1, record a mismatch flag and go to STOP.
- STOP: at edge P-1, evaluate the voted stop bit and go to IDLE. In the following cycle:
  - if stop=1 and no parity mismatch: p_data <= shift register, data_valid=1;
  - if a parity mismatch was recorded: par_err=1;
  - if stop=0: stop_err=1;
  - par_err and stop_err may pulse together; when either is set, data_valid=0 and p_data is unchanged.

Frame timing:
- data_valid/error pulses occur exactly N*P cycles after the first rx_s=0 cycle of the frame, where N = 1 + datawidth + par_en + 1.

Back-to-back frames:
- IDLE may detect the next start bit in the same cycle as the output pulse, so there are no lost frames at zero inter-frame gap.

Break condition:
- A line held at 0 gives stop_err, then IDLE immediately re-detects a start bit.
- The receiver keeps reporting stop_err until the line returns high.

Mid-frame reset:
- The frame is abandoned and no pulses are produced.
- After reset release the FSM waits in IDLE for a fresh falling edge.

Test Plan:
- Reset: assert rst mid-DATA -> outputs 0 immediately; after release, a clean 0xA5 frame (P=8, par_en=0) -> data_valid exactly once, p_data=0xA5.
- Even parity: P=8, par_en=1, par_typ=0, send 0x3C with parity bit 0 -> data_valid pulse 88 cycles after first rx_s=0, p_data=0x3C, par_err=0.
- Parity error: P=16, odd parity, send 0x01 with parity bit 1 (wrong) -> par_err single pulse, data_valid=0, p_data keeps its previous value.
- Stop error and glitch: P=8, frame 0x55 with stop bit 0 -> stop_err pulse only. Separately, a 2-cycle low glitch on rx_in -> no pulses, FSM back in IDLE.
- Majority vote: P=32, flip one of the 3 sample points in every data bit of 0xF0 -> p_data=0xF0, no errors.
- Back-to-back: P=8, par_en=0, frames 0x12 then 0x34 with zero gap -> two data_valid pulses 80 cycles apart, p_data=0x12 then 0x34.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop synchronizer, runtime-prescaled oversampling with
// 3-sample majority vote, optional even/odd parity, one stop bit. Good words are
// delivered as a one-cycle data_valid pulse; framing and parity faults as error pulses.
module uart_rx_core #(
   parameter int unsigned datawidth  = 8,
   parameter int unsigned prescale_w = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [prescale_w-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [datawidth-1:0]  p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stop_err
);

   localparam int unsigned BitW = (datawidth > 1) ? $clog2(datawidth) : 1;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                state_q, state_d;
   logic [1:0]            sync_q;
   logic [prescale_w-1:0] edge_q, edge_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [2:0]            samp_q, samp_d;
   logic [datawidth-1:0]  shift_q, shift_d;
   logic [prescale_w-1:0] pscale_q, pscale_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  par_mis_q, par_mis_d;
   logic [datawidth-1:0]  p_data_q, p_data_d;
   logic                  dv_q, dv_d;
   logic                  pe_q, pe_d;
   logic                  se_q, se_d;

   logic                  rx_s;
   logic [prescale_w-1:0] half;
   logic                  last_edge;
   logic                  vote;

   assign rx_s      = sync_q[1];
   assign half      = pscale_q >> 1;
   assign last_edge = (edge_q == pscale_q - prescale_w'(1));
   assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                      (samp_q[1] & samp_q[2]);

   // State, counters, sample/shift datapath and registered output pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= 2'b11;
         state_q   <= StIdle;
         edge_q    <= '0;
         bit_q     <= '0;
         samp_q    <= '0;
         shift_q   <= '0;
         pscale_q  <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         par_mis_q <= 1'b0;
         p_data_q  <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx_in};
         state_q   <= state_d;
         edge_q    <= edge_d;
         bit_q     <= bit_d;
         samp_q    <= samp_d;
         shift_q   <= shift_d;
         pscale_q  <= pscale_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         par_mis_q <= par_mis_d;
         p_data_q  <= p_data_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
   end

   // Next-state logic: bit timing, majority sampling, frame decode and pulse generation
   always_comb begin
      state_d   = state_q;
      edge_d    = edge_q;
      bit_d     = bit_q;
      samp_d    = samp_q;
      shift_d   = shift_q;
      pscale_d  = pscale_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      par_mis_d = par_mis_q;
      p_data_d  = p_data_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;

      if (state_q != StIdle) begin
         edge_d = last_edge ? '0 : edge_q + prescale_w'(1);
         if (edge_q == half - prescale_w'(1)) samp_d[0] = rx_s;
         if (edge_q == half)                  samp_d[1] = rx_s;
         if (edge_q == half + prescale_w'(1)) samp_d[2] = rx_s;
      end

      case (state_q)
         StIdle: begin
            edge_d = '0;
            if (!rx_s) begin
               // This cycle is edge 0 of the start bit
               state_d   = StStart;
               edge_d    = prescale_w'(1);
               bit_d     = '0;
               par_mis_d = 1'b0;
               pscale_d  = prescale;
               par_en_d  = par_en;
               par_typ_d = par_typ;
            end
         end
         StStart: begin
            if (last_edge) state_d = vote ? StIdle : StData;
         end
         StData: begin
            if (last_edge) begin
               shift_d = {vote, shift_q[datawidth-1:1]};
               bit_d   = bit_q + BitW'(1);
               if (bit_q == BitW'(datawidth - 1)) begin
                  bit_d   = '0;
                  state_d = par_en_q ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (last_edge) begin
               par_mis_d = vote ^ (^shift_q) ^ par_typ_q;
               state_d   = StStop;
            end
         end
         StStop: begin
            if (last_edge) begin
               state_d = StIdle;
               if (vote && !par_mis_q) begin
                  p_data_d = shift_q;
                  dv_d     = 1'b1;
               end
               pe_d = par_mis_q;
               se_d = ~vote;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign p_data     = p_data_q;
   assign data_valid = dv_q;
   assign par_err    = pe_q;
   assign stop_err   = se_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: directed scenarios plus randomized frames, checked
// against a frame-level model (bit list -> expected pulse time, flags and word).
module tb_uart_rx_core;

   logic       clk;
   logic       rst;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en;
   logic       par_typ;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stop_err;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int         obs_cyc[$];
   logic [10:0] obs_val[$];
   int         exp_cyc[$];
   logic [10:0] exp_val[$];
   logic [7:0] last_good;

   uart_rx_core dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stop_err   (stop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pulse with the cycle it was seen in
   always @(negedge clk) begin
      if (data_valid || par_err || stop_err) begin
         obs_cyc.push_back(cyc);
         obs_val.push_back({data_valid, par_err, stop_err, p_data});
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_p();
      case ($urandom_range(0, 2))
         0:       return 8;
         1:       return 16;
         default: return 32;
      endcase
   endfunction

   // Drive one frame cycle by cycle and queue the model's expected outcome
   task automatic send(input logic [7:0] data, input int p, input logic pe, input logic pt,
                       input logic bad_par, input logic stop_bit, input logic flip);
      logic [10:0] bits;
      int          nb;
      int          fall;
      int          fp[9];
      logic        v;
      logic        ok;
      nb   = pe ? 11 : 10;
      bits = '1;
      bits[0] = 1'b0;
      for (int b = 0; b < 8; b++) bits[1+b] = data[b];
      if (pe) begin
         bits[9]  = (^data) ^ pt ^ bad_par;
         bits[10] = stop_bit;
      end else begin
         bits[9] = stop_bit;
      end
      for (int b = 0; b < 9; b++) fp[b] = $urandom_range(0, 2);
      fall = 0;
      for (int i = 0; i < nb * p; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            prescale = 6'(p);
            par_en   = pe;
            par_typ  = pt;
            fall     = cyc;
         end
         if (i == p + 1) begin
            // Configuration must be ignored once the frame is under way
            prescale = 6'(pick_p());
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
         end
         v = bits[i / p];
         if (flip && (i / p) >= 1 && (i / p) <= 8 && (i % p) == (p / 2 - 1 + fp[i / p]))
            v = ~v;
         rx_in = v;
      end
      ok = stop_bit && !(pe && bad_par);
      if (ok) last_good = data;
      exp_cyc.push_back(fall + 2 + nb * p);
      exp_val.push_back({ok, pe & bad_par, ~stop_bit, last_good});
   endtask

   // Return line to idle, wait for expected pulses (bounded), compare all of them
   task automatic check_frames(input string tag);
      int t;
      @(posedge clk); #1;
      rx_in = 1'b1;
      t = 0;
      while (obs_cyc.size() < exp_cyc.size() && t < 2000) begin
         @(posedge clk);
         t++;
      end
      repeat (8) @(posedge clk);
      chk({tag, "/pulse_count"}, obs_cyc.size(), exp_cyc.size());
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         chk({tag, "/pulse_cycle"}, obs_cyc[i], exp_cyc[i]);
         chk({tag, "/dv_pe_se_data"}, {21'd0, obs_val[i]}, {21'd0, exp_val[i]});
      end
      obs_cyc.delete();
      obs_val.delete();
      exp_cyc.delete();
      exp_val.delete();
   endtask

   initial begin
      int fall;
      rst       = 1'b1;
      rx_in     = 1'b1;
      prescale  = 6'd8;
      par_en    = 1'b0;
      par_typ   = 1'b0;
      last_good = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset/p_data", p_data, 0);
      chk("reset/data_valid", data_valid, 0);
      chk("reset/par_err", par_err, 0);
      chk("reset/stop_err", stop_err, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // Even parity, P=8: pulse 88 cycles after first rx_s low
      send(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_frames("even_parity");

      // Reset in the middle of the data bits of an 0xA5 frame
      prescale = 6'd8;
      par_en   = 1'b0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         rx_in = (i < 8) ? 1'b0 : ((8'hA5 >> ((i - 8) / 8)) & 8'h01) != 0;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("midrst/p_data", p_data, 0);
      chk("midrst/data_valid", data_valid, 0);
      chk("midrst/par_err", par_err, 0);
      chk("midrst/stop_err", stop_err, 0);
      rx_in     = 1'b1;
      last_good = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_frames("midrst_abort");
      send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_frames("after_reset");

      // Odd parity, P=16, wrong parity bit
      send(8'h01, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check_frames("parity_err");

      // Stop bit sampled low
      send(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_frames("stop_err");

      // Two-cycle low glitch must be rejected, then a normal frame still decodes
      prescale = 6'd8;
      par_en   = 1'b0;
      @(posedge clk); #1;
      rx_in = 1'b0;
      @(posedge clk); #1;
      rx_in = 1'b0;
      @(posedge clk); #1;
      rx_in = 1'b1;
      repeat (20) @(posedge clk);
      check_frames("glitch");
      send(8'h69, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_frames("post_glitch");

      // One sample point flipped in every data bit, P=32
      send(8'hF0, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_frames("majority");

      // Back-to-back frames with zero gap
      send(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_frames("back_to_back");

      // Break: line low for two whole frames gives two stop errors
      prescale = 6'd8;
      par_en   = 1'b0;
      fall     = 0;
      for (int i = 0; i < 160; i++) begin
         @(posedge clk); #1;
         if (i == 0) fall = cyc;
         rx_in = 1'b0;
      end
      exp_cyc.push_back(fall + 2 + 80);
      exp_val.push_back({1'b0, 1'b0, 1'b1, last_good});
      exp_cyc.push_back(fall + 2 + 160);
      exp_val.push_back({1'b0, 1'b0, 1'b1, last_good});
      check_frames("break");

      // Randomized frames
      for (int n = 0; n < 20; n++) begin
         logic pe;
         pe = 1'($urandom);
         send(8'($urandom), pick_p(), pe, 1'($urandom), pe && ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) != 0), 1'($urandom));
         if ($urandom_range(0, 1) == 0) check_frames("random");
      end
      check_frames("random_tail");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
